layerio_tile_reader: RTL

- Tile buffer directly upstream of arith on the layer-input (a) path. It accepts featuremap rows from the layer-input writer and stores them as whole tiles of SZI rows.
- On a read request it streams one complete tile as SZI consecutive valid rows. It tags the rows with new_tile_k / last_elm info and drives the rdready / half_full status that arith uses to pace a-tile reads.
- Partial final tiles of a layer are zero-padded on read, so gemm always sees full tiles.

---
 rtl/layerio_tile_reader_if.sv | 33 +++
 rtl/layerio_tile_reader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/layerio_tile_reader_if.sv
// Row-write / tile-read bundle between the layer-input writer, the a-tile buffer and arith.
// master drives writes and read requests; slave is the tile buffer.
interface layerio_tile_reader_if #(
  parameter int SZJ     = 16,
  parameter int A_WIDTH = 8
);
  logic                   wrreq;
  logic [SZJ*A_WIDTH-1:0] d;
  logic                   d_last;
  logic                   wrready;
  logic                   rdreq;
  logic                   rdready;
  logic                   half_full;
  logic                   empty;
  logic [SZJ*A_WIDTH-1:0] q;
  logic                   q_valid;
  logic                   q_new_tile_k;
  logic                   q_last_elm;
  logic                   err_overflow;
  logic                   err_rdreq;

  modport master (
    output wrreq, d, d_last, rdreq,
    input  wrready, rdready, half_full, empty, q, q_valid, q_new_tile_k, q_last_elm,
           err_overflow, err_rdreq
  );

  modport slave (
    input  wrreq, d, d_last, rdreq,
    output wrready, rdready, half_full, empty, q, q_valid, q_new_tile_k, q_last_elm,
           err_overflow, err_rdreq
  );
endinterface

// File: rtl/layerio_tile_reader.sv
// Tile buffer on the layer-input (a) path: collects rows into SZI-row tiles and streams
// one whole tile per rdreq, zero-padding short final tiles so gemm always sees full tiles.
module layerio_tile_reader #(
  parameter int SZI         = 16,
  parameter int SZJ         = 16,
  parameter int A_WIDTH     = 8,
  parameter int DEPTH_TILES = 4,
  parameter int RDLATENCY   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  layerio_tile_reader_if.slave  bus
);
  localparam int DW     = SZJ * A_WIDTH;
  localparam int ROW_W  = $clog2(SZI);
  localparam int SLOT_W = $clog2(DEPTH_TILES);
  localparam int CNT_W  = SLOT_W + 1;
  localparam int ADDR_W = SLOT_W + ROW_W;

  typedef enum logic [0:0] {IDLE, READ} state_t;

  typedef struct packed {
    logic vld;
    logic pad;
    logic first;
    logic last;
  } tag_t;

  logic [DW-1:0]    mem [DEPTH_TILES*SZI];
  logic [ROW_W:0]   row_count_reg [DEPTH_TILES];
  logic             layer_last_reg [DEPTH_TILES];

  state_t           state_reg, state_next;
  logic [SLOT_W-1:0] wr_slot_reg, rd_slot_reg, rd_slot_next;
  logic [ROW_W-1:0] wr_row_reg, wr_row_next, rd_row_reg, rd_row_next;
  logic [CNT_W-1:0] closed_reg, closed_next;
  logic             half_full_reg, empty_reg, err_overflow_reg, err_rdreq_reg;

  logic             wr_ok, wr_close, rd_accept, issue, tile_free;
  logic [ROW_W-1:0] issue_row;
  logic [ADDR_W-1:0] rd_addr;

  logic [DW-1:0]    data_pipe [RDLATENCY+1];
  tag_t             tag_pipe  [RDLATENCY+1];
  tag_t             tag_out;

  assign bus.wrready = (closed_reg < CNT_W'(DEPTH_TILES));
  assign bus.rdready = (state_reg == IDLE) && (closed_reg != '0);
  assign wr_ok       = bus.wrreq && bus.wrready;
  assign wr_close    = wr_ok && (bus.d_last || (wr_row_reg == ROW_W'(SZI-1)));
  assign rd_accept   = bus.rdreq && bus.rdready;
  assign rd_addr     = {rd_slot_reg, issue_row};

  always_comb begin
    wr_row_next = wr_row_reg;
    if (wr_close)
      wr_row_next = '0;
    else if (wr_ok)
      wr_row_next = wr_row_reg + ROW_W'(1);
  end

  always_comb begin
    closed_next = closed_reg;
    if (wr_close && !tile_free)
      closed_next = closed_reg + CNT_W'(1);
    else if (!wr_close && tile_free)
      closed_next = closed_reg - CNT_W'(1);
  end

  // Row 0 is issued in the accepting cycle, so the last row goes out SZI-1 cycles later
  // and a rdreq in the very next cycle continues the stream without a bubble.
  always_comb begin
    state_next   = state_reg;
    rd_row_next  = rd_row_reg;
    rd_slot_next = rd_slot_reg;
    issue        = 1'b0;
    issue_row    = rd_row_reg;
    tile_free    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (rd_accept) begin
          issue       = 1'b1;
          issue_row   = '0;
          rd_row_next = ROW_W'(1);
          state_next  = READ;
        end
      end
      READ: begin
        issue = 1'b1;
        if (rd_row_reg == ROW_W'(SZI-1)) begin
          tile_free    = 1'b1;
          rd_slot_next = rd_slot_reg + SLOT_W'(1);
          rd_row_next  = '0;
          state_next   = IDLE;
        end else begin
          rd_row_next = rd_row_reg + ROW_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      rd_row_reg       <= '0;
      rd_slot_reg      <= '0;
      wr_slot_reg      <= '0;
      wr_row_reg       <= '0;
      closed_reg       <= '0;
      half_full_reg    <= 1'b0;
      empty_reg        <= 1'b1;
      err_overflow_reg <= 1'b0;
      err_rdreq_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rd_row_reg    <= rd_row_next;
      rd_slot_reg   <= rd_slot_next;
      wr_row_reg    <= wr_row_next;
      closed_reg    <= closed_next;
      half_full_reg <= (closed_next >= CNT_W'(DEPTH_TILES/2));
      empty_reg     <= (closed_next == '0) && (wr_row_next == '0);
      if (wr_close)
        wr_slot_reg <= wr_slot_reg + SLOT_W'(1);
      if (bus.wrreq && !bus.wrready)
        err_overflow_reg <= 1'b1;
      if (bus.rdreq && !bus.rdready)
        err_rdreq_reg <= 1'b1;
    end
  end

  // Slot metadata is captured when the tile closes.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH_TILES; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (reset) begin
          row_count_reg[gi]  <= '0;
          layer_last_reg[gi] <= 1'b0;
        end else if (wr_close && (wr_slot_reg == SLOT_W'(gi))) begin
          row_count_reg[gi]  <= {1'b0, wr_row_reg} + (ROW_W+1)'(1);
          layer_last_reg[gi] <= bus.d_last;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[{wr_slot_reg, wr_row_reg}] <= bus.d;
  end

  always_ff @(posedge clk) begin
    data_pipe[0] <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_pipe[0] <= '0;
    end else begin
      tag_pipe[0].vld   <= issue;
      tag_pipe[0].pad   <= issue && ({1'b0, issue_row} >= row_count_reg[rd_slot_reg]);
      tag_pipe[0].first <= issue && (issue_row == '0);
      tag_pipe[0].last  <= issue && (issue_row == ROW_W'(SZI-1)) && layer_last_reg[rd_slot_reg];
    end
  end

  // Tags ride alongside the RAM output so pad/first/last line up with their row.
  generate
    for (gi = 1; gi <= RDLATENCY; gi++) begin : g_pipe
      always_ff @(posedge clk) begin
        data_pipe[gi] <= data_pipe[gi-1];
        if (reset)
          tag_pipe[gi] <= '0;
        else
          tag_pipe[gi] <= tag_pipe[gi-1];
      end
    end
  endgenerate

  assign tag_out          = tag_pipe[RDLATENCY];
  assign bus.q_valid      = tag_out.vld;
  assign bus.q            = (tag_out.vld && !tag_out.pad) ? data_pipe[RDLATENCY] : '0;
  assign bus.q_new_tile_k = tag_out.first;
  assign bus.q_last_elm   = tag_out.last;
  assign bus.half_full    = half_full_reg;
  assign bus.empty        = empty_reg;
  assign bus.err_overflow = err_overflow_reg;
  assign bus.err_rdreq    = err_rdreq_reg;
endmodule
